mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the instruction-fetch unit (IF) and the load/store unit (LS) inside Computer.
- Arbitrates between the two requesters and sequences each access through a fixed-latency memory.
- Returns the read data, or a write completion, to the requester that was granted.
- Exactly one memory transaction is in flight at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the byte-strobe width is DATA_W/8.
- MEM_LATENCY, 2, number of cycles from the mem_en cycle to valid mem_rdata; must be ≥1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request; held high until if_ready is seen.
- if_addr  in  ADDR_W  fetch address.
- if_ready  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  DATA_W  fetched word.
- ls_req  in  1  load/store request; held high until ls_ready is seen.
- ls_we  in  1  1 = store, 0 = load.
- ls_wstrb  in  DATA_W/8  byte enables for a store.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_ready  out  1  one-cycle pulse: load/store request accepted.
- ls_rvalid  out  1  one-cycle pulse: load data valid, or store complete.
- ls_rdata  out  DATA_W  load data; 0 for a store.
- mem_en  out  1  one-cycle memory access strobe.
- mem_we  out  1  memory write enable.
- mem_wstrb  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid exactly MEM_LATENCY cycles after the mem_en cycle.

Behaviour:
- State machine states: IDLE, ISSUE, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=IF, last_grant=LS (so IF wins the first tie).
  - Counter cleared; all latched address/data/strobe registers cleared.
  - Every output is 0.
  - Reset asserted mid-transaction aborts it silently: no rvalid is produced.
  - The memory result arriving later is ignored.
- IDLE:
  - Neither request high: remain in IDLE; all outputs 0.
  - Exactly one request high: grant that requester.
  - Both high: grant the requester that is not last_grant (strict round-robin).
  - On a grant: latch owner and the owner's addr/we/wstrb/wdata; update last_grant; go to ISSUE.
  - IF requests are latched with we=0 and wstrb=0.
- ISSUE (one cycle):
  - mem_en=1; mem_* driven from the latched fields.
  - The owner's ready pulses high; the other requester's ready stays 0.
  - Counter loaded with MEM_LATENCY; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1: capture mem_rdata (or 0 if the access is a write) into the owner's rdata register; go to RESP.
- RESP (one cycle):
  - Owner's rvalid=1; go to IDLE.
  - A request visible in this cycle is arbitrated in the following IDLE cycle.
- mem_* outputs are 0 whenever mem_en=0.
- Non-owner rdata registers hold their previous values.
- Latency, request seen in IDLE at cycle T:
  - ready and mem_en at T+1.
  - mem_rdata sampled at T+1+MEM_LATENCY.
  - rvalid at T+2+MEM_LATENCY.
  - Peak throughput: one transaction per MEM_LATENCY+3 cycles.
- Requester inputs sampled outside IDLE are ignored.
  - A requester that drops req after being latched still receives its rvalid.
- Addresses and strobes pass through unmodified; the arbiter performs no alignment check.
- Outputs are Moore-decoded from state and registers; there is no combinational path from any input to any output.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE/ISSUE/WAIT/RESP);
  - owner encoding (OWN_IF=0, OWN_LS=1);
  - default widths.
- One sub-module, rr_arbiter2: 2-way round-robin grant logic (inputs: two reqs, last_grant; output: grant), reusable elsewhere.
- Counter width is $clog2(MEM_LATENCY+1).

Test Plan:
All scenarios use MEM_LATENCY=2 and a memory model whose rdata = addr ^ 32'hA5A5_A5A5.
1. IF-only read: if_req=1, if_addr=0x10 at cycle 0 -> if_ready=1 and mem_en=1 (mem_addr=0x10) at cycle 1; if_rvalid=1 with if_rdata=0xA5A5_A5B5 at cycle 4; ls_* outputs stay 0 throughout.
2. LS store: ls_req=1, ls_we=1, ls_wstrb=4'b0011, ls_addr=0x40, ls_wdata=0xDEAD_BEEF -> mem_we=1, mem_wstrb=0011, mem_wdata=0xDEAD_BEEF at cycle 1; ls_rvalid=1 with ls_rdata=0 at cycle 4.
3. Simultaneous requests from reset: IF (0x0) and LS load (0x80) held high -> IF granted first (if_ready at cycle 1, if_rvalid at cycle 4); LS granted next (ls_ready at cycle 6, ls_rvalid=1 with ls_rdata=0xA5A5_A525 at cycle 9).
4. Sustained contention: both reqs held high for 30 cycles -> grants alternate IF, LS, IF, LS; no two consecutive grants go to the same requester; mem_en never high in two adjacent cycles.
5. Reset mid-operation: pull reset low during WAIT -> all outputs 0 immediately; after release with no reqs, neither rvalid ever pulses; the next IF request completes normally.
6. Request dropped after latch: ls_req high for one cycle only -> ls_ready at cycle 1 and ls_rvalid at cycle 4 still occur; no second transaction is issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/LS memory-port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MEM_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_IF) ? OWN_LS : OWN_IF;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the side
// that did not win last time.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_grant,
  output owner_t     grant
);

  always_comb begin
    grant = OWN_IF;
    if (req == 2'b11) grant = other_owner(last_grant);
    else if (req[1])  grant = OWN_LS;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// load/store; one transaction in flight, outputs decoded from registered state.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_ready,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);

  state_t              state, state_nxt;
  owner_t              owner, last_grant, grant;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;
  logic                any_req, load, capture;
  logic [DATA_W-1:0]   rdata_cap;

  rr_arbiter2 u_rr (
    .req        ({ls_req, if_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign any_req   = if_req | ls_req;
  assign load      = (state == ST_IDLE) && any_req;
  assign capture   = (state == ST_WAIT) && (cnt == CNT_ONE);
  assign rdata_cap = we_q ? '0 : mem_rdata;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state defaults to the current state before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == CNT_ONE) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every latched field is reset, not just control, so the outputs and
  // any later debug view start from known zeros.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_IF;
      last_grant <= OWN_LS;
      cnt        <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (load) begin
        owner      <= grant;
        last_grant <= grant;
        if (grant == OWN_IF) begin
          addr_q  <= if_addr;
          we_q    <= 1'b0;
          wstrb_q <= '0;
          wdata_q <= '0;
        end else begin
          addr_q  <= ls_addr;
          we_q    <= ls_we;
          wstrb_q <= ls_wstrb;
          wdata_q <= ls_wdata;
        end
      end
      if (state == ST_ISSUE)     cnt <= CNT_LOAD;
      else if (state == ST_WAIT) cnt <= cnt - CNT_ONE;
      if (capture) begin
        if (owner == OWN_IF) if_rdata_q <= rdata_cap;
        else                 ls_rdata_q <= rdata_cap;
      end
    end
  end

  // Read data is only presented alongside its rvalid; the registers hold otherwise.
  always_comb begin
    if_ready  = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_ready  = 1'b0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_wstrb = wstrb_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (owner == OWN_IF) if_ready = 1'b1;
        else                 ls_ready = 1'b1;
      end
      ST_RESP: begin
        if (owner == OWN_IF) begin
          if_rvalid = 1'b1;
          if_rdata  = if_rdata_q;
        end else begin
          ls_rvalid = 1'b1;
          ls_rdata  = ls_rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model
// that schedules each grant's ready/mem_en/rvalid cycles from the grant cycle.
module tb_mem_port_arbiter;

  localparam int L = 2;
  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clock, reset;
  logic        if_req, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ready, ls_rvalid;
  logic [3:0]  ls_wstrb;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_wstrb  (ls_wstrb),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_ready  (ls_ready),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory: data for the mem_en cycle appears L cycles later; garbage otherwise.
  logic [31:0] mem_pipe [L];
  always @(posedge clock) begin
    mem_pipe[0] <= mem_en ? (mem_addr ^ K) : $urandom;
    for (int i = 1; i < L; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_rdata = mem_pipe[L-1];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction, described by its grant cycle.
  bit          m_busy, m_own, m_we, m_last;
  int          m_g;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  logic        e_if_ready, e_if_rvalid, e_ls_ready, e_ls_rvalid, e_mem_en, e_mem_we;
  logic [31:0] e_if_rdata, e_ls_rdata, e_mem_addr, e_mem_wdata;
  logic [3:0]  e_mem_wstrb;

  bit obs_if_ready, obs_ls_ready, prev_mem_en;
  bit chk_alt, have_prev, prev_ls;

  task automatic clear_expect();
    e_if_ready = 0; e_if_rvalid = 0; e_if_rdata = '0;
    e_ls_ready = 0; e_ls_rvalid = 0; e_ls_rdata = '0;
    e_mem_en = 0; e_mem_we = 0; e_mem_wstrb = '0; e_mem_addr = '0; e_mem_wdata = '0;
  endtask

  task automatic compare_all(input string p);
    check({p, "if_ready"},  if_ready,  e_if_ready);
    check({p, "if_rvalid"}, if_rvalid, e_if_rvalid);
    check({p, "if_rdata"},  if_rdata,  e_if_rdata);
    check({p, "ls_ready"},  ls_ready,  e_ls_ready);
    check({p, "ls_rvalid"}, ls_rvalid, e_ls_rvalid);
    check({p, "ls_rdata"},  ls_rdata,  e_ls_rdata);
    check({p, "mem_en"},    mem_en,    e_mem_en);
    check({p, "mem_we"},    mem_we,    e_mem_we);
    check({p, "mem_wstrb"}, mem_wstrb, e_mem_wstrb);
    check({p, "mem_addr"},  mem_addr,  e_mem_addr);
    check({p, "mem_wdata"}, mem_wdata, e_mem_wdata);
  endtask

  // One clock cycle: check this cycle's outputs, drive this cycle's inputs, advance the model.
  task automatic cycle(input bit ir, input logic [31:0] ia, input bit lr, input bit lw,
                       input logic [3:0] lsb, input logic [31:0] la, input logic [31:0] ld);
    int k;
    @(negedge clock);
    k = cyc - m_g;
    clear_expect();
    if (m_busy && k == 1) begin
      e_mem_en = 1; e_mem_we = m_we; e_mem_wstrb = m_wstrb;
      e_mem_addr = m_addr; e_mem_wdata = m_wdata;
      if (m_own) e_ls_ready = 1; else e_if_ready = 1;
    end
    if (m_busy && k == L + 2) begin
      if (m_own) begin e_ls_rvalid = 1; e_ls_rdata = m_we ? 32'h0 : (m_addr ^ K); end
      else       begin e_if_rvalid = 1; e_if_rdata = m_addr ^ K; end
    end
    compare_all("");
    check("mem_en_adjacent", mem_en & prev_mem_en, 1'b0);
    if (chk_alt && (if_ready || ls_ready)) begin
      if (have_prev) check("grant_alternates", ls_ready, !prev_ls);
      have_prev = 1; prev_ls = ls_ready;
    end
    prev_mem_en  = mem_en;
    obs_if_ready = if_ready;
    obs_ls_ready = ls_ready;

    if_req = ir; if_addr = ia;
    ls_req = lr; ls_we = lw; ls_wstrb = lsb; ls_addr = la; ls_wdata = ld;

    if (!m_busy) begin
      if (ir || lr) begin
        m_own  = (ir && lr) ? !m_last : lr;
        m_last = m_own;
        m_busy = 1;
        m_g    = cyc;
        if (m_own) begin m_addr = la; m_we = lw; m_wstrb = lsb; m_wdata = ld; end
        else       begin m_addr = ia; m_we = 0;  m_wstrb = '0;  m_wdata = '0; end
      end
    end else if (k == L + 2) begin
      m_busy = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic apply_reset();
    #1 reset = 1'b0;
    #1;
    clear_expect();
    compare_all("rst_");
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_wstrb = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    m_busy = 0; m_last = 1; prev_mem_en = 0; obs_if_ready = 0; obs_ls_ready = 0;
  endtask

  bit          ih, lh, r_lw;
  logic [31:0] r_ia, r_la, r_ld;
  logic [3:0]  r_ls;

  task automatic run_random(input int n, input int pct);
    ih = 0; lh = 0;
    for (int i = 0; i < n; i++) begin
      if (ih && obs_if_ready) ih = 0;
      if (lh && obs_ls_ready) lh = 0;
      if (!ih && int'($urandom_range(99)) < pct) begin ih = 1; r_ia = $urandom; end
      if (!lh && int'($urandom_range(99)) < pct) begin
        lh = 1; r_lw = 1'($urandom_range(1)); r_ls = 4'($urandom);
        r_la = $urandom; r_ld = $urandom;
      end
      if (!ih) r_ia = $urandom;
      cycle(ih, r_ia, lh, r_lw, r_ls, r_la, r_ld);
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_wstrb = '0; ls_addr = '0; ls_wdata = '0;
    m_busy = 0; m_last = 1; m_g = 0;
    #2;
    apply_reset();

    // IF-only read of 0x10
    cycle(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    idle(6);

    // LS store
    cycle(0, 32'h0, 1, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
    idle(6);

    // Simultaneous requests from reset: IF first, LS load held until ls_ready
    apply_reset();
    for (int i = 0; i < 7; i++) cycle(i == 0, 32'h0, 1, 0, 4'h0, 32'h80, 32'h0);
    idle(5);

    // Reset during WAIT, then idle, then a normal fetch
    cycle(1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0);
    idle(2);
    apply_reset();
    idle(8);
    cycle(1, 32'h30, 0, 0, 4'h0, 32'h0, 32'h0);
    idle(6);

    // LS request dropped after one cycle
    cycle(0, 32'h0, 1, 0, 4'hF, 32'h44, 32'h0);
    idle(8);

    // Sustained contention
    chk_alt = 1; have_prev = 0;
    run_random(30, 100);
    chk_alt = 0;
    idle(6);

    run_random(1200, 30);
    run_random(400, 80);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
